// File: rtl/ap_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package : ap_mon_pkg
// Brief   : Shared types and read-field codes for ap_ctrl_perf_monitor.
// Rev     : 1.0
// ============================================================================
package ap_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_RUN  = 2'd1,
        MON_HOLD = 2'd2
    } ap_mon_state_e;

    localparam logic [1:0] ST_IDLE = MON_IDLE;
    localparam logic [1:0] ST_RUN  = MON_RUN;
    localparam logic [1:0] ST_HOLD = MON_HOLD;

    localparam logic [2:0] FLD_COUNT     = 3'd0;
    localparam logic [2:0] FLD_LAST_LAT  = 3'd1;
    localparam logic [2:0] FLD_MIN_LAT   = 3'd2;
    localparam logic [2:0] FLD_MAX_LAT   = 3'd3;
    localparam logic [2:0] FLD_BUSY      = 3'd4;
    localparam logic [2:0] FLD_LAST_INTV = 3'd5;
    localparam logic [2:0] FLD_STALL     = 3'd6;
    localparam logic [2:0] FLD_STATE     = 3'd7;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ap_ctrl_chan_stats.sv
`default_nettype none
// ============================================================================
// Module  : ap_ctrl_chan_stats
// Brief   : One channel's handshake FSM and saturating statistics counters.
//           Stall counter present only with APMON_STALL_CNT_EN defined.
// Rev     : 1.0
// ============================================================================
module ap_ctrl_chan_stats
    import ap_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_ap_start,
    input  logic             i_ap_ready,
    input  logic             i_ap_done,
    input  logic             i_ap_continue,
    input  logic             i_freeze,
    input  logic             i_clear,
    input  logic [2:0]       i_rd_field,
    output logic [CNT_W-1:0] o_field_data
);

    localparam logic [CNT_W-1:0] CNT_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(64'(v), CNT_W));
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] lat_run_q, lat_run_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] last_lat_q, last_lat_d;
    logic [CNT_W-1:0] min_lat_q, min_lat_d;
    logic [CNT_W-1:0] max_lat_q, max_lat_d;
    logic [CNT_W-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] intv_run_q, intv_run_d;
    logic [CNT_W-1:0] last_intv_q, last_intv_d;
    logic             intv_seen_q, intv_seen_d;
    logic             rec;
    logic [CNT_W-1:0] rec_lat;
    logic             accept;
    logic [CNT_W-1:0] stall_val;

    assign accept = i_ap_start & i_ap_ready;

    // FSM keeps tracking under freeze/clear; only the statistics are gated.
    always_comb begin
        state_d   = state_q;
        lat_run_d = lat_run_q;
        rec       = 1'b0;
        rec_lat   = lat_run_q;
        case (state_q)
            ST_IDLE: begin
                if (i_ap_start) begin
                    lat_run_d = CNT_ONE;
                    if (i_ap_done) begin
                        rec     = 1'b1;
                        rec_lat = '0;
                        state_d = i_ap_continue ? ST_IDLE : ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!i_freeze) lat_run_d = inc(lat_run_q);
                if (i_ap_done) begin
                    rec     = 1'b1;
                    rec_lat = lat_run_q;
                    state_d = i_ap_continue ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_ap_continue) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        last_lat_d  = last_lat_q;
        min_lat_d   = min_lat_q;
        max_lat_d   = max_lat_q;
        busy_d      = busy_q;
        intv_run_d  = intv_run_q;
        last_intv_d = last_intv_q;
        intv_seen_d = intv_seen_q;
        if (i_clear) begin
            count_d     = '0;
            last_lat_d  = '0;
            min_lat_d   = CNT_ONES;
            max_lat_d   = '0;
            busy_d      = '0;
            intv_run_d  = '0;
            last_intv_d = '0;
            intv_seen_d = 1'b0;
        end else if (!i_freeze) begin
            if (rec) begin
                count_d    = inc(count_q);
                last_lat_d = rec_lat;
                if (rec_lat < min_lat_q) min_lat_d = rec_lat;
                if (rec_lat > max_lat_q) max_lat_d = rec_lat;
            end
            if (state_q != ST_IDLE) busy_d = inc(busy_q);
            if (accept) begin
                if (intv_seen_q) last_intv_d = intv_run_q;
                intv_run_d  = CNT_ONE;
                intv_seen_d = 1'b1;
            end else if (intv_seen_q) begin
                intv_run_d = inc(intv_run_q);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lat_run_q   <= '0;
            count_q     <= '0;
            last_lat_q  <= '0;
            min_lat_q   <= CNT_ONES;
            max_lat_q   <= '0;
            busy_q      <= '0;
            intv_run_q  <= '0;
            last_intv_q <= '0;
            intv_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_run_q   <= lat_run_d;
            count_q     <= count_d;
            last_lat_q  <= last_lat_d;
            min_lat_q   <= min_lat_d;
            max_lat_q   <= max_lat_d;
            busy_q      <= busy_d;
            intv_run_q  <= intv_run_d;
            last_intv_q <= last_intv_d;
            intv_seen_q <= intv_seen_d;
        end
    end

`ifdef APMON_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (i_clear) stall_d = '0;
        else if (!i_freeze && state_q == ST_HOLD) stall_d = inc(stall_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_val = stall_q;
`else
    assign stall_val = '0;
`endif

    always_comb begin
        o_field_data = '0;
        case (i_rd_field)
            FLD_COUNT:     o_field_data = count_q;
            FLD_LAST_LAT:  o_field_data = last_lat_q;
            FLD_MIN_LAT:   o_field_data = min_lat_q;
            FLD_MAX_LAT:   o_field_data = max_lat_q;
            FLD_BUSY:      o_field_data = busy_q;
            FLD_LAST_INTV: o_field_data = last_intv_q;
            FLD_STALL:     o_field_data = stall_val;
            FLD_STATE:     o_field_data = CNT_W'(state_q);
            default:       o_field_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ap_ctrl_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module  : ap_ctrl_perf_monitor
// Brief   : NUM_CH ap_ctrl handshake statistics with registered readout.
//           APMON_STALL_CNT_EN enables the per-channel HOLD stall counter.
// Rev     : 1.0
// ============================================================================
module ap_ctrl_perf_monitor
    import ap_mon_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              freeze,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_field,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid
);

    logic [CNT_W-1:0] ch_data [NUM_CH];
    logic [CNT_W-1:0] sel_data;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        ap_ctrl_chan_stats #(
            .CNT_W(CNT_W)
        ) u_stats (
            .clock        (clock),
            .reset        (reset),
            .i_ap_start   (ap_start[g]),
            .i_ap_ready   (ap_ready[g]),
            .i_ap_done    (ap_done[g]),
            .i_ap_continue(ap_continue[g]),
            .i_freeze     (freeze),
            .i_clear      (clear),
            .i_rd_field   (rd_field),
            .o_field_data (ch_data[g])
        );
    end

    // Unmatched channel codes (rd_ch >= NUM_CH) fall through to zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) sel_data = ch_data[i];
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? sel_data : rd_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ap_ctrl_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_ap_ctrl_perf_monitor
// Brief   : Self-checking bench for ap_ctrl_perf_monitor (32-bit 4-channel and
//           8-bit 1-channel instances). Honours APMON_STALL_CNT_EN.
// Rev     : 1.0
// ============================================================================
module tb_ap_ctrl_perf_monitor;
    import ap_mon_pkg::*;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } exp_t;

    typedef struct {
        int          ch;
        int          fld;
        logic [63:0] exp;
        string       name;
    } vec_t;

`ifdef APMON_STALL_CNT_EN
    localparam logic [63:0] STALL_EXP = 64'd4;
`else
    localparam logic [63:0] STALL_EXP = 64'd0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  ap_start, ap_ready, ap_done, ap_continue;
    logic        freeze, clear, rd_en;
    logic [1:0]  rd_ch;
    logic [2:0]  rd_field;
    logic [31:0] rd_data;
    logic        rd_valid;

    logic        rst8;
    logic [0:0]  s8_start, s8_ready, s8_done, s8_cont;
    logic        freeze8, clear8, rd8_en;
    logic [0:0]  rd8_ch;
    logic [2:0]  rd8_field;
    logic [7:0]  rd8_data;
    logic        rd8_valid;

    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t sb8[$];
    vec_t vecs[$];
    exp_t mon_e;
    exp_t mon8_e;

    ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32)) dut (
        .clock(clk), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .freeze(freeze), .clear(clear),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_field(rd_field),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    ap_ctrl_perf_monitor #(.NUM_CH(1), .CNT_W(8)) dut8 (
        .clock(clk), .reset(rst8),
        .ap_start(s8_start), .ap_ready(s8_ready), .ap_done(s8_done), .ap_continue(s8_cont),
        .freeze(freeze8), .clear(clear8),
        .rd_en(rd8_en), .rd_ch(rd8_ch), .rd_field(rd8_field),
        .rd_data(rd8_data), .rd_valid(rd8_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rd_valid: got data %0h with no read outstanding", rd_data);
            end else begin
                mon_e = sb.pop_front();
                if (64'(rd_data) !== mon_e.exp) begin
                    failures++;
                    $display("FAIL %s: got %0h expected %0h", mon_e.name, rd_data, mon_e.exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rd8_valid) begin
            checks++;
            if (sb8.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rd8_valid: got data %0h with no read outstanding", rd8_data);
            end else begin
                mon8_e = sb8.pop_front();
                if (64'(rd8_data) !== mon8_e.exp) begin
                    failures++;
                    $display("FAIL %s: got %0h expected %0h", mon8_e.name, rd8_data, mon8_e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input int ch, input int fld, input logic [63:0] e, input string n);
        vec_t v;
        v.ch = ch; v.fld = fld; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input int ch, input int fld, input logic [63:0] e, input string nm);
        exp_t x;
        x.name = nm; x.exp = e;
        sb.push_back(x);
        rd_en = 1'b1; rd_ch = 2'(ch); rd_field = 3'(fld);
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic rd8(input int ch, input int fld, input logic [63:0] e, input string nm);
        exp_t x;
        x.name = nm; x.exp = e;
        sb8.push_back(x);
        rd8_en = 1'b1; rd8_ch = 1'(ch); rd8_field = 3'(fld);
        tick(1);
        rd8_en = 1'b0;
    endtask

    // Accepted start; done 'lat' cycles later (same cycle when lat==0), continue high.
    task automatic txn(input int ch, input int lat);
        ap_start[ch] = 1'b1; ap_ready[ch] = 1'b1;
        if (lat == 0) ap_done[ch] = 1'b1;
        tick(1);
        ap_start[ch] = 1'b0; ap_ready[ch] = 1'b0; ap_done[ch] = 1'b0;
        if (lat > 0) begin
            tick(lat - 1);
            ap_done[ch] = 1'b1;
            tick(1);
            ap_done[ch] = 1'b0;
        end
    endtask

    initial begin
        checks = 0; failures = 0;

        vecs.push_back(mk(0, FLD_COUNT,     1,  "ch0_count"));
        vecs.push_back(mk(0, FLD_LAST_LAT,  5,  "ch0_last_lat"));
        vecs.push_back(mk(0, FLD_MIN_LAT,   5,  "ch0_min_lat"));
        vecs.push_back(mk(0, FLD_MAX_LAT,   5,  "ch0_max_lat"));
        vecs.push_back(mk(0, FLD_BUSY,      5,  "ch0_busy"));
        vecs.push_back(mk(0, FLD_STATE,     0,  "ch0_state"));
        vecs.push_back(mk(1, FLD_COUNT,     3,  "ch1_count"));
        vecs.push_back(mk(1, FLD_LAST_LAT,  9,  "ch1_last_lat"));
        vecs.push_back(mk(1, FLD_MIN_LAT,   3,  "ch1_min_lat"));
        vecs.push_back(mk(1, FLD_MAX_LAT,   9,  "ch1_max_lat"));
        vecs.push_back(mk(1, FLD_BUSY,      19, "ch1_busy"));
        vecs.push_back(mk(1, FLD_LAST_INTV, 20, "ch1_last_intv"));
        vecs.push_back(mk(2, FLD_COUNT,     1,  "ch2_count"));
        vecs.push_back(mk(2, FLD_LAST_LAT,  5,  "ch2_last_lat"));
        vecs.push_back(mk(2, FLD_BUSY,      9,  "ch2_busy"));
        vecs.push_back(mk(2, FLD_STALL, STALL_EXP, "ch2_stall"));
        vecs.push_back(mk(2, FLD_LAST_INTV, 0,  "ch2_last_intv"));
        vecs.push_back(mk(3, FLD_COUNT,     1,  "ch3_count_frozen"));
        vecs.push_back(mk(3, FLD_LAST_LAT,  0,  "ch3_last_lat"));
        vecs.push_back(mk(3, FLD_MIN_LAT,   0,  "ch3_min_lat"));
        vecs.push_back(mk(3, FLD_MAX_LAT,   0,  "ch3_max_lat_frozen"));
        vecs.push_back(mk(3, FLD_BUSY,      0,  "ch3_busy_frozen"));

        reset = 1'b1; rst8 = 1'b1;
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
        freeze = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_field = '0;
        s8_start = '0; s8_ready = '0; s8_done = '0; s8_cont = '1;
        freeze8 = 1'b0; clear8 = 1'b0; rd8_en = 1'b0; rd8_ch = '0; rd8_field = '0;
        tick(3);
        reset = 1'b0; rst8 = 1'b0;
        tick(2);

        rd(0, FLD_COUNT,   0,             "rst_count");
        rd(0, FLD_MIN_LAT, 64'hFFFF_FFFF, "rst_min_lat");
        rd(3, FLD_STATE,   0,             "rst_state");
        rd8(0, FLD_MIN_LAT, 64'hFF,       "rst8_min_lat");

        txn(0, 5);
        tick(2);
        txn(1, 7); tick(12);
        txn(1, 3); tick(16);
        txn(1, 9); tick(2);

        // ch2: done with continue low, state read while parked in HOLD
        ap_start[2] = 1'b1; ap_ready[2] = 1'b1;
        tick(1);
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
        tick(4);
        ap_done[2] = 1'b1; ap_continue[2] = 1'b0;
        tick(1);
        ap_done[2] = 1'b0;
        tick(1);
        rd(2, FLD_STATE, 2, "ch2_state_hold");
        tick(1);
        ap_continue[2] = 1'b1;
        tick(2);

        txn(3, 0);
        tick(2);
        freeze = 1'b1;
        txn(3, 4);
        freeze = 1'b0;
        tick(2);

        for (int i = 0; i < vecs.size(); i++) begin
            rd(vecs[i].ch, vecs[i].fld, vecs[i].exp, vecs[i].name);
        end
        tick(2);

        // Clear 4 cycles into a ch0 transaction that completes 6 cycles later
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        tick(1);
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        tick(3);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(5);
        ap_done[0] = 1'b1;
        tick(1);
        ap_done[0] = 1'b0;
        tick(1);
        rd(0, FLD_COUNT,     1,             "clr_ch0_count");
        rd(0, FLD_LAST_LAT,  10,            "clr_ch0_last_lat");
        rd(0, FLD_MIN_LAT,   10,            "clr_ch0_min_lat");
        rd(0, FLD_BUSY,      6,             "clr_ch0_busy");
        rd(0, FLD_LAST_INTV, 0,             "clr_ch0_last_intv");
        rd(1, FLD_COUNT,     0,             "clr_ch1_count");
        rd(1, FLD_MIN_LAT,   64'hFFFF_FFFF, "clr_ch1_min_lat");

        // 8-bit instance: 300-cycle transaction saturates
        s8_start = 1'b1; s8_ready = 1'b1;
        tick(1);
        s8_start = 1'b0; s8_ready = 1'b0;
        tick(100);
        rd8(0, FLD_STATE, 1, "w8_state_run");
        tick(198);
        s8_done = 1'b1;
        tick(1);
        s8_done = 1'b0;
        tick(1);
        rd8(0, FLD_COUNT,    1,     "w8_count");
        rd8(0, FLD_LAST_LAT, 255,   "w8_last_lat_sat");
        rd8(0, FLD_MAX_LAT,  255,   "w8_max_lat_sat");
        rd8(0, FLD_BUSY,     255,   "w8_busy_sat");
        rd8(1, FLD_COUNT,    0,     "w8_out_of_range_ch");

        // Asynchronous reset in the middle of a RUN
        s8_start = 1'b1; s8_ready = 1'b1;
        tick(1);
        s8_start = 1'b0; s8_ready = 1'b0;
        tick(10);
        #3 rst8 = 1'b1;
        #2 rst8 = 1'b0;
        tick(1);
        rd8(0, FLD_COUNT,    0,     "arst_count");
        rd8(0, FLD_LAST_LAT, 0,     "arst_last_lat");
        rd8(0, FLD_MIN_LAT,  64'hFF, "arst_min_lat");
        rd8(0, FLD_BUSY,     0,     "arst_busy");
        rd8(0, FLD_STATE,    0,     "arst_state");
        tick(4);

        checks++;
        if (sb.size() != 0 || sb8.size() != 0) begin
            failures++;
            $display("FAIL read_drain: got %0d outstanding reads expected 0", sb.size() + sb8.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
